// File: rtl/seg_defs.sv
// seg_defs: shared 7-segment symbol constants and active-low segment code table
package seg_defs;
  localparam logic [3:0] SYM_DASH = 4'd10;
  localparam logic [3:0] SYM_BLANK = 4'd15;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF = 8'hFF;
  localparam logic [5:0] SNAP_RST = 6'b010000;
  localparam logic [6:0] SEG_CODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational symbol to active-low g..a segment decode
module bcd_to_seg7
  import seg_defs::*;
(
  input  logic [3:0] sym,
  output logic [6:0] seg
);
  assign seg = SEG_CODE[sym];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 8-digit multiplexed 7-segment scanner with per-frame snapshot,
// anti-ghost blanking and per-digit blink
module seg_scan_driver
  import seg_defs::*;
#(
  parameter int DIGIT_DIV = 100000,
  parameter int BLANK_CYCLES = 2000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] led0,
  input  logic [5:0] led1,
  input  logic [5:0] led2,
  input  logic [5:0] led3,
  input  logic [5:0] led4,
  input  logic [5:0] led5,
  input  logic [5:0] led6,
  input  logic [5:0] led7,
  output logic [7:0] an,
  output logic [7:0] seg
);
  localparam int SW = $clog2(DIGIT_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  logic [SW-1:0] slot_cnt;
  logic [BW-1:0] blink_cnt;
  logic [2:0] idx;
  logic blink_on;
  logic [5:0] snap [8];
  logic [5:0] led_in [8];
  logic [5:0] cur;
  logic [6:0] dec;
  logic slot_end, blink_end, blank;
  logic [7:0] an_nxt, seg_nxt;
  assign led_in = '{led0, led1, led2, led3, led4, led5, led6, led7};
  assign cur = snap[idx];
  bcd_to_seg7 u_dec (.sym(cur[3:0]), .seg(dec));
  always_comb begin
    slot_end = slot_cnt == SW'(DIGIT_DIV - 1);
    blink_end = blink_cnt == BW'(BLINK_DIV - 1);
    blank = slot_cnt < SW'(BLANK_CYCLES);
    an_nxt = blank ? AN_OFF : ~(8'd1 << idx);
    seg_nxt = (blank || (cur[5] && !blink_on)) ? SEG_OFF : {cur[4], dec};
  end
  // snapshot is taken on the last clock of the frame so every digit of a frame
  // comes from the same input sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      blink_cnt <= '0;
      idx <= '0;
      blink_on <= 1'b1;
      an <= AN_OFF;
      seg <= SEG_OFF;
      for (int i = 0; i < 8; i++) snap[i] <= SNAP_RST;
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
      blink_cnt <= blink_end ? '0 : blink_cnt + 1'b1;
      if (blink_end) blink_on <= ~blink_on;
      if (slot_end) idx <= idx + 3'd1;
      if (slot_end && idx == 3'd7)
        for (int i = 0; i < 8; i++) snap[i] <= led_in[i];
      an <= an_nxt;
      seg <= seg_nxt;
    end
  end
endmodule
